poly_tone_gen: RTL and testbench

POLY_TONE_GEN -- requirements
Module: poly_tone_gen

---
 rtl/poly_tone_gen.sv | 213 +++++++++++++++++++++
 tb/tb_poly_tone_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
`default_nettype none
// ============================================================================
// Module  : poly_tone_gen
// Purpose : NUM_CH-voice phase-accumulator tone generator producing one mixed
//           signed sample per Fs tick. Define POLY_TONE_TRIANGLE_EN to add a
//           per-channel triangle waveform select (wave_sel).
// Rev     : 1.0
// ============================================================================
module poly_tone_gen #(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 24,
    parameter int SAMPLE_W = 16,
    parameter int DIV      = 1042
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [4*NUM_CH-1:0]        note,
    input  logic [2*NUM_CH-1:0]        octave,
`ifdef POLY_TONE_TRIANGLE_EN
    input  logic [NUM_CH-1:0]          wave_sel,
`endif
    input  logic                       sample_ready,
    input  logic                       overrun_clr,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(DIV);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_amp_int = ((2 ** (SAMPLE_W - 1)) - 1) >> $clog2(NUM_CH);
    localparam logic signed [SAMPLE_W:0] c_amp = c_amp_int[SAMPLE_W:0];

    // Phase increment for note n: round(f(n) * 2^ACC_W * DIV / 50 MHz), f in micro-hertz.
    function automatic logic [ACC_W-1:0] f_inc(input int n);
        logic [127:0] v_fu;
        logic [127:0] v_num;
        case (n)
            0:       v_fu = 128'd261625565;
            1:       v_fu = 128'd277182631;
            2:       v_fu = 128'd293664768;
            3:       v_fu = 128'd311126984;
            4:       v_fu = 128'd329627557;
            5:       v_fu = 128'd349228231;
            6:       v_fu = 128'd369994423;
            7:       v_fu = 128'd391995436;
            8:       v_fu = 128'd415304698;
            9:       v_fu = 128'd440000000;
            10:      v_fu = 128'd466163762;
            11:      v_fu = 128'd493883301;
            default: v_fu = '0;
        endcase
        v_num = ((v_fu * 128'(DIV)) << ACC_W) + 128'd25_000_000_000_000;
        v_num = v_num / 128'd50_000_000_000_000;
        return v_num[ACC_W-1:0];
    endfunction

    localparam logic [ACC_W-1:0] c_inc [16] = '{
        f_inc(0),  f_inc(1),  f_inc(2),  f_inc(3),
        f_inc(4),  f_inc(5),  f_inc(6),  f_inc(7),
        f_inc(8),  f_inc(9),  f_inc(10), f_inc(11),
        f_inc(12), f_inc(13), f_inc(14), f_inc(15)
    };

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CH_W-1:0]             r_ch;
    logic [NUM_CH-1:0]           r_en;
    logic [4*NUM_CH-1:0]         r_note;
    logic [2*NUM_CH-1:0]         r_oct;
    logic [ACC_W-1:0]            r_acc [NUM_CH];
    logic signed [SAMPLE_W:0]    r_sum;
    logic signed [SAMPLE_W-1:0]  r_sample;
    logic                        r_valid;
    logic                        r_ovr;

    logic                        w_tick;
    logic                        w_last;
    logic                        w_drop;
    logic                        w_xfer;
    logic [3:0]                  w_note;
    logic [1:0]                  w_oct;
    logic                        w_live;
    logic [ACC_W-1:0]            w_step;
    logic [ACC_W-1:0]            w_acc_nxt;
    logic signed [SAMPLE_W:0]    w_sq;
    logic signed [SAMPLE_W:0]    w_contrib;
    logic signed [SAMPLE_W:0]    w_sum_nxt;

    assign w_tick    = (r_cnt == CNT_W'(DIV - 1));
    assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
    assign w_drop    = w_tick && (r_state != S_IDLE);
    assign w_xfer    = (r_state == S_PRESENT) && r_valid && sample_ready;
    assign w_note    = r_note[4*r_ch +: 4];
    assign w_oct     = r_oct[2*r_ch +: 2];
    assign w_live    = r_en[r_ch] && (w_note < 4'd12);
    assign w_step    = c_inc[w_note] << w_oct;
    assign w_acc_nxt = w_live ? (r_acc[r_ch] + w_step) : '0;
    assign w_sq      = w_acc_nxt[ACC_W-1] ? -c_amp : c_amp;
    assign w_sum_nxt = r_sum + w_contrib;

`ifdef POLY_TONE_TRIANGLE_EN
    logic [NUM_CH-1:0]           r_wsel;
    logic [SAMPLE_W-1:0]         w_tri_lvl;
    logic [2*SAMPLE_W-1:0]       w_tri_prod;
    logic [SAMPLE_W-1:0]         w_tri_mag;
    logic signed [SAMPLE_W:0]    w_tri;

    // Fold the phase into a rising/falling ramp, then scale 0..2^SAMPLE_W-1 onto -AMP..+AMP.
    assign w_tri_lvl  = w_acc_nxt[ACC_W-2 -: SAMPLE_W] ^ {SAMPLE_W{w_acc_nxt[ACC_W-1]}};
    assign w_tri_prod = (2*SAMPLE_W)'(w_tri_lvl) * (2*SAMPLE_W)'(2 * c_amp_int + 1);
    assign w_tri_mag  = SAMPLE_W'(w_tri_prod >> SAMPLE_W);
    assign w_tri      = $signed({1'b0, w_tri_mag}) - c_amp;

    always_comb begin
        w_contrib = '0;
        if (w_live) begin
            w_contrib = r_wsel[r_ch] ? w_tri : w_sq;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_wsel <= '0;
        end else if (w_tick && (r_state == S_IDLE)) begin
            r_wsel <= wave_sel;
        end
    end
`else
    always_comb begin
        w_contrib = '0;
        if (w_live) begin
            w_contrib = w_sq;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_tick) w_state_nxt = S_ACCUM;
            S_ACCUM:   if (w_last) w_state_nxt = S_PRESENT;
            S_PRESENT: if (w_xfer) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_ch     <= '0;
            r_en     <= '0;
            r_note   <= '0;
            r_oct    <= '0;
            r_sum    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick && (r_state == S_IDLE)) begin
                r_en   <= ch_en;
                r_note <= note;
                r_oct  <= octave;
                r_ch   <= '0;
                r_sum  <= '0;
            end
            if (r_state == S_ACCUM) begin
                r_acc[r_ch] <= w_acc_nxt;
                r_sum       <= w_sum_nxt;
                r_ch        <= r_ch + 1'b1;
                if (w_last) begin
                    r_sample <= w_sum_nxt[SAMPLE_W-1:0];
                    r_valid  <= 1'b1;
                end
            end
            if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // A dropped tick wins over a simultaneous clear.
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (overrun_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_poly_tone_gen
// Purpose : Scoreboard bench for poly_tone_gen against a tick-level tone model.
// Rev     : 1.0
// ============================================================================
module tb_poly_tone_gen;

    localparam int NUM_CH   = 4;
    localparam int ACC_W    = 24;
    localparam int SAMPLE_W = 16;
    localparam int DIV      = 1042;
    localparam int AMP      = ((1 << (SAMPLE_W - 1)) - 1) / NUM_CH;
    localparam int unsigned MASK = (1 << ACC_W) - 1;
    localparam int unsigned HALF = 1 << (ACC_W - 1);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_CH-1:0]          ch_en = '0;
    logic [4*NUM_CH-1:0]        note = '0;
    logic [2*NUM_CH-1:0]        octave = '0;
    logic                       sample_ready = 1'b1;
    logic                       overrun_clr = 1'b0;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic                       overrun;
`ifdef POLY_TONE_TRIANGLE_EN
    logic [NUM_CH-1:0]          wave_sel = '0;
`endif

    always #5 clk = ~clk;

    poly_tone_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .SAMPLE_W (SAMPLE_W),
        .DIV      (DIV)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst_n),
        .ch_en        (ch_en),
        .note         (note),
        .octave       (octave),
`ifdef POLY_TONE_TRIANGLE_EN
        .wave_sel     (wave_sel),
`endif
        .sample_ready (sample_ready),
        .overrun_clr  (overrun_clr),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    int          total = 0;
    int          bad   = 0;
    int          inc_tab [16];
    int unsigned m_phase [NUM_CH];
    int          exp_q [$];
    bit          m_busy, m_valid, m_ovr;
    int          m_cnt;
    longint      m_edge;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Mixed sample for one accepted tick, straight from the tone rules.
    function automatic int mix();
        int s;
        int n;
        int o;
        int unsigned p;
        s = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            n = int'(note[4*c +: 4]);
            o = int'(octave[2*c +: 2]);
            if (ch_en[c] && n < 12) begin
                m_phase[c] = (m_phase[c] + (int'(inc_tab[n]) << o)) & MASK;
`ifdef POLY_TONE_TRIANGLE_EN
                if (wave_sel[c]) begin
                    p = m_phase[c];
                    if (p >= HALF) p = MASK - p;
                    s += int'(((p >> (ACC_W - 1 - SAMPLE_W)) * (2 * AMP + 1)) >> SAMPLE_W) - AMP;
                end else
`endif
                s += (m_phase[c] >= HALF) ? -AMP : AMP;
            end else begin
                m_phase[c] = 0;
            end
        end
        return s;
    endfunction

    // Reference model: a tick every DIV edges; busy from an accepted tick until transfer.
    initial begin
        bit busy_before;
        bit tick;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_valid = 0; m_ovr = 0; m_cnt = 0; m_edge = 0;
                exp_q.delete();
                for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
            end else begin
                m_edge++;
                tick = (m_edge % DIV) == 0;
                busy_before = m_busy;
                if (m_valid && sample_ready) begin
                    m_valid = 0;
                    m_busy  = 0;
                end else if (m_busy && !m_valid) begin
                    m_cnt--;
                    if (m_cnt == 0) m_valid = 1;
                end
                if (tick && busy_before) m_ovr = 1;
                else if (overrun_clr) m_ovr = 0;
                if (tick && !busy_before) begin
                    exp_q.push_back(mix());
                    m_busy = 1;
                    m_cnt  = NUM_CH;
                end
            end
        end
    end

    // Monitor: handshake timing, sticky flag and sample contents at each transfer.
    initial begin
        int want;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", sample_valid, m_valid);
                check("overrun", overrun, m_ovr);
                if (sample_valid && sample_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sample: got %0d expected none (queue empty) at %0t", sample, $time);
                    end else begin
                        want = exp_q.pop_front();
                        check("sample", $signed(sample), want);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int c, input bit en, input int n, input int o);
        ch_en[c] = en;
        note[4*c +: 4] = 4'(n);
        octave[2*c +: 2] = 2'(o);
    endtask

    task automatic wait_valid(input string name);
        int k;
        for (k = 0; k < 2 * DIV && !sample_valid; k++) cyc(1);
        if (!sample_valid) begin
            total++; bad++;
            $display("FAIL %s: got no sample_valid expected one within %0d cycles", name, 2 * DIV);
        end
    endtask

    initial begin
        logic signed [SAMPLE_W-1:0] s0;
        int k;
        for (int n = 0; n < 16; n++) begin
            inc_tab[n] = (n < 12) ?
                $rtoi(440.0 * (2.0 ** ((n - 9) / 12.0)) * (2.0 ** ACC_W) * DIV / 50.0e6 + 0.5) : 0;
        end

        cyc(3);
        check("rst_sample", $signed(sample), 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Single A voice, high octave so several half-periods fit in the run.
        set_ch(0, 1, 9, 3);
        cyc(14 * DIV);

        // All four voices in phase on C: full-scale +/-4*AMP.
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1, 0, 1);
        cyc(4 * DIV);
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1, 0, 3);
        cyc(12 * DIV);

        // Invalid note silences the only enabled channel.
        ch_en = '0;
        set_ch(0, 1, 13, 0);
        cyc(4 * DIV);

        // Stalled consumer across two ticks, then clear the sticky flag.
        set_ch(0, 1, 9, 3);
        sample_ready = 1'b0;
        wait_valid("stall_valid");
        s0 = sample;
        cyc(2 * DIV);
        check("stall_valid_held", sample_valid, 1);
        check("stall_sample_held", $signed(sample), $signed(s0));
        check("stall_overrun", overrun, 1);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
        sample_ready = 1'b1;
        cyc(2 * DIV);

        // Randomized voices, consumer back-pressure and clear pulses.
        k = 0;
        while (k < 14 * DIV) begin
            int seg;
            bit stall;
            ch_en  = NUM_CH'($urandom);
            note   = (4*NUM_CH)'($urandom);
            octave = (2*NUM_CH)'($urandom);
`ifdef POLY_TONE_TRIANGLE_EN
            wave_sel = NUM_CH'($urandom);
`endif
            seg   = $urandom_range(20, 600);
            stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < seg; i++) begin
                sample_ready = stall ? 1'b0 : ($urandom_range(0, 9) < 8);
                overrun_clr  = ($urandom_range(0, 49) == 0);
                cyc(1);
            end
            k += seg;
        end
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;

        // Asynchronous reset in the middle of accumulation, with overrun set.
        ch_en = '0;
        set_ch(0, 1, 9, 3);
        sample_ready = 1'b0;
        wait_valid("pre_reset_valid");
        cyc(DIV + 5);
        sample_ready = 1'b1;
        for (k = 0; k < 2 * DIV && !(m_busy && !m_valid); k++) cyc(1);
        if (!(m_busy && !m_valid)) begin
            total++; bad++;
            $display("FAIL accum_wait: got no accumulation expected one within %0d cycles", 2 * DIV);
        end
        rst_n = 1'b0;
        cyc(1);
        check("midreset_sample", $signed(sample), 0);
        check("midreset_valid", sample_valid, 0);
        check("midreset_overrun", overrun, 0);
        rst_n = 1'b1;
        cyc(2 * DIV + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
